// File: rtl/game_pkg.sv
// Shared types and default parameters for the game-level sequencer.
//   game_state_t : round state as seen on the game_ctrl state port
//   FPS          : frames per timer wrap (timer runs 0..FPS-1)
//   *_DEF        : default round tuning values used by game_ctrl
package game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } game_state_t;

    localparam int unsigned FPS                   = 60;
    localparam int unsigned SPEED_INIT_DEF        = 6;
    localparam int unsigned SPEED_MAX_DEF         = 13;
    localparam int unsigned SPEED_STEP_FRAMES_DEF = 600;
    localparam int unsigned SCORE_MAX_DEF         = 99_999;

    localparam int unsigned TIMER_W = 6;
    localparam int unsigned SPEED_W = 4;
    localparam int unsigned SCORE_W = 17;
    localparam int unsigned SUM_W   = 18;

endpackage

// File: rtl/debouncer.sv
// Button conditioner: 2-flop synchronizer followed by a stable-count debouncer.
//   clk, rst     : clock, asynchronous active-low reset
//   btn_i        : raw asynchronous button level
//   btn_db_o     : debounced level, changes after DEBOUNCE_CYCLES stable clocks
//   btn_rise_o   : one-cycle pulse coincident with each 0->1 change of btn_db_o
module debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic btn_db_o,
    output logic btn_rise_o
);

    localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_q, db_d;
    logic             rise_q, rise_d;

    // Synchronizer, stable counter and outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            db_q    <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            rise_q  <= rise_d;
        end
    end

    // Count consecutive clocks of disagreement; any agreement restarts the count
    always_comb begin
        cnt_d  = '0;
        db_d   = db_q;
        rise_d = 1'b0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d   = sync2_q;
                rise_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign btn_db_o   = db_q;
    assign btn_rise_o = rise_q;

endmodule

// File: rtl/game_ctrl.sv
// Game-level sequencer: frame divider, animation timer, round FSM,
// speed ramp, distance score and restart pulse.
//   clk, rst   : clock, asynchronous active-low reset
//   btn_jump   : raw jump button (async, active-high)
//   crash      : collision level, synchronous to clk
//   frame_tick : one-cycle pulse per frame
//   timer      : frame index 0..59
//   speed      : scroll speed
//   jump       : debounced jump level, forced low in OVER and on restart
//   restart    : one-cycle pulse when a round restarts from OVER
//   state      : game_state_t
//   score      : saturating distance score
module game_ctrl
    import game_pkg::*;
#(
    parameter int unsigned CLK_PER_FRAME     = 1_666_666,
    parameter int unsigned DEBOUNCE_CYCLES   = 1_000_000,
    parameter int unsigned SPEED_INIT        = SPEED_INIT_DEF,
    parameter int unsigned SPEED_MAX         = SPEED_MAX_DEF,
    parameter int unsigned SPEED_STEP_FRAMES = SPEED_STEP_FRAMES_DEF,
    parameter int unsigned SCORE_MAX         = SCORE_MAX_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn_jump,
    input  logic                crash,
    output logic                frame_tick,
    output logic [TIMER_W-1:0]  timer,
    output logic [SPEED_W-1:0]  speed,
    output logic                jump,
    output logic                restart,
    output logic [1:0]          state,
    output logic [SCORE_W-1:0]  score
);

    localparam int unsigned       DIV_W      = $clog2(CLK_PER_FRAME);
    localparam int unsigned       STEP_W     = $clog2(SPEED_STEP_FRAMES + 1);
    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_PER_FRAME - 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(FPS - 1);

    logic btn_db, btn_rise;

    game_state_t        state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               tick_q, tick_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [STEP_W-1:0]  step_q, step_d, step_inc;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SUM_W-1:0]   score_sum;
    logic               jump_q, jump_d;
    logic               restart_q, restart_d;

    debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk        (clk),
        .rst        (rst),
        .btn_i      (btn_jump),
        .btn_db_o   (btn_db),
        .btn_rise_o (btn_rise)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            div_q     <= '0;
            tick_q    <= 1'b0;
            timer_q   <= '0;
            step_q    <= '0;
            speed_q   <= SPEED_W'(SPEED_INIT);
            score_q   <= '0;
            jump_q    <= 1'b0;
            restart_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            tick_q    <= tick_d;
            timer_q   <= timer_d;
            step_q    <= step_d;
            speed_q   <= speed_d;
            score_q   <= score_d;
            jump_q    <= jump_d;
            restart_q <= restart_d;
        end
    end

    // Next-state: divider, timer, round FSM, ramp and score
    always_comb begin
        state_d   = state_q;
        div_d     = div_q + DIV_W'(1);
        tick_d    = 1'b0;
        timer_d   = timer_q;
        step_d    = step_q;
        step_inc  = step_q + STEP_W'(1);
        speed_d   = speed_q;
        score_d   = score_q;
        score_sum = SUM_W'(score_q) + SUM_W'(speed_q);
        restart_d = 1'b0;
        jump_d    = 1'b0;

        // Tick is registered so it is high while the counter holds its last value
        if (div_q == DIV_LAST) begin
            div_d = '0;
        end
        tick_d = (div_d == DIV_LAST);

        if (tick_q) begin
            timer_d = (timer_q == TIMER_LAST) ? '0 : timer_q + TIMER_W'(1);
        end

        case (state_q)
            IDLE: begin
                speed_d = SPEED_W'(SPEED_INIT);
                score_d = '0;
                step_d  = '0;
                if (btn_rise) begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                // Crash takes priority over a coincident frame update
                if (crash) begin
                    state_d = OVER;
                end else if (tick_q) begin
                    score_d = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX)
                                                              : score_sum[SCORE_W-1:0];
                    if (step_inc == STEP_W'(SPEED_STEP_FRAMES)) begin
                        step_d  = '0;
                        speed_d = (speed_q >= SPEED_W'(SPEED_MAX)) ? SPEED_W'(SPEED_MAX)
                                                                   : speed_q + SPEED_W'(1);
                    end else begin
                        step_d = step_inc;
                    end
                end
            end
            OVER: begin
                // Only a fresh debounced rising edge restarts; a held button has no edge
                if (btn_rise) begin
                    state_d   = PLAY;
                    restart_d = 1'b1;
                    score_d   = '0;
                    speed_d   = SPEED_W'(SPEED_INIT);
                    step_d    = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if ((state_d != OVER) && !restart_d) begin
            jump_d = btn_db;
        end
    end

    assign frame_tick = tick_q;
    assign timer      = timer_q;
    assign speed      = speed_q;
    assign jump       = jump_q;
    assign restart    = restart_q;
    assign state      = state_q;
    assign score      = score_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with a short frame, short debounce and small score cap.
module tb_game_ctrl;

    logic        clk;
    logic        rst;
    logic        btn_jump;
    logic        crash;
    logic        frame_tick;
    logic [5:0]  timer;
    logic [3:0]  speed;
    logic        jump;
    logic        restart;
    logic [1:0]  state;
    logic [16:0] score;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc     = 0;

    typedef struct {
        logic btn;
        logic crs;
        int   at;
        int   st;
        int   sc;
        int   sp;
        logic jmp;
        logic rs;
    } vec_t;

    vec_t vecs[$];

    game_ctrl #(
        .CLK_PER_FRAME     (4),
        .DEBOUNCE_CYCLES   (3),
        .SPEED_STEP_FRAMES (5),
        .SCORE_MAX         (100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_jump   (btn_jump),
        .crash      (crash),
        .frame_tick (frame_tick),
        .timer      (timer),
        .speed      (speed),
        .jump       (jump),
        .restart    (restart),
        .state      (state),
        .score      (score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vec_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic vec_t v(input logic b, input logic c, input int at, input int st,
                               input int sc, input int sp, input logic j, input logic r);
        vec_t x;
        x.btn = b; x.crs = c; x.at = at; x.st = st;
        x.sc = sc; x.sp = sp; x.jmp = j; x.rs = r;
        return x;
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, " frame_tick"}, int'(frame_tick), 0);
        chk({tag, " timer"},      int'(timer),      0);
        chk({tag, " jump"},       int'(jump),       0);
        chk({tag, " restart"},    int'(restart),    0);
        chk({tag, " score"},      int'(score),      0);
        chk({tag, " state"},      int'(state),      0);
        chk({tag, " speed"},      int'(speed),      6);
    endtask

    initial begin
        // Inputs take effect at the next clock; cyc = clocks since reset release.
        // Bounce, with crash in IDLE ignored
        vecs.push_back(v(1, 1, 242, 0,   0,  6, 0, 0));
        vecs.push_back(v(0, 0, 246, 0,   0,  6, 0, 0));
        vecs.push_back(v(1, 0, 248, 0,   0,  6, 0, 0));
        vecs.push_back(v(0, 0, 252, 0,   0,  6, 0, 0));
        // Clean press at 252: jump and PLAY 6 clocks later
        vecs.push_back(v(1, 0, 257, 0,   0,  6, 0, 0));
        vecs.push_back(v(1, 0, 258, 1,   0,  6, 1, 0));
        // Ramp: ticks at 259, 263, ...
        vecs.push_back(v(1, 0, 259, 1,   0,  6, 1, 0));
        vecs.push_back(v(1, 0, 260, 1,   6,  6, 1, 0));
        vecs.push_back(v(1, 0, 275, 1,  24,  6, 1, 0));
        vecs.push_back(v(1, 0, 276, 1,  30,  7, 1, 0));
        vecs.push_back(v(1, 0, 280, 1,  37,  7, 1, 0));
        vecs.push_back(v(1, 0, 312, 1,  97,  8, 1, 0));
        vecs.push_back(v(1, 0, 316, 1, 100,  9, 1, 0));
        vecs.push_back(v(1, 0, 396, 1, 100, 13, 1, 0));
        vecs.push_back(v(1, 0, 420, 1, 100, 13, 1, 0));
        // Crash off-tick, button held through it: no restart
        vecs.push_back(v(1, 1, 421, 2, 100, 13, 0, 0));
        vecs.push_back(v(1, 0, 440, 2, 100, 13, 0, 0));
        vecs.push_back(v(0, 0, 450, 2, 100, 13, 0, 0));
        // Fresh press at 450 restarts at 456 (coincides with a tick in OVER)
        vecs.push_back(v(1, 0, 455, 2, 100, 13, 0, 0));
        vecs.push_back(v(1, 0, 456, 1,   0,  6, 0, 1));
        vecs.push_back(v(1, 0, 457, 1,   0,  6, 1, 0));
        // Round 2: crash on the same cycle as frame_tick freezes score 37
        vecs.push_back(v(1, 0, 476, 1,  30,  7, 1, 0));
        vecs.push_back(v(1, 0, 483, 1,  37,  7, 1, 0));
        vecs.push_back(v(1, 1, 484, 2,  37,  7, 0, 0));
        vecs.push_back(v(1, 1, 504, 2,  37,  7, 0, 0));
        vecs.push_back(v(0, 0, 512, 2,  37,  7, 0, 0));
        vecs.push_back(v(1, 0, 517, 2,  37,  7, 0, 0));
        vecs.push_back(v(1, 0, 518, 1,   0,  6, 0, 1));
        vecs.push_back(v(1, 0, 519, 1,   0,  6, 1, 0));
        // Round 3 up to the mid-round reset
        vecs.push_back(v(1, 0, 530, 1,  18,  6, 1, 0));
        vecs.push_back(v(0, 0, 536, 1,  30,  7, 0, 0));

        rst      = 1'b0;
        btn_jump = 1'b0;
        crash    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("por");

        @(negedge clk);
        rst = 1'b1;

        // Free run: tick every 4th clock, timer wraps after 60 ticks
        for (int k = 1; k <= 240; k++) begin
            step();
            chk("free frame_tick", int'(frame_tick), ((cyc % 4) == 3) ? 1 : 0);
            chk("free timer", int'(timer), (cyc / 4) % 60);
        end
        chk("free state", int'(state), 0);
        chk("free score", int'(score), 0);
        chk("free jump",  int'(jump),  0);

        foreach (vecs[i]) begin
            btn_jump = vecs[i].btn;
            crash    = vecs[i].crs;
            while (cyc < vecs[i].at) step();
            chk($sformatf("v%0d state",   i), int'(state),   vecs[i].st);
            chk($sformatf("v%0d score",   i), int'(score),   vecs[i].sc);
            chk($sformatf("v%0d speed",   i), int'(speed),   vecs[i].sp);
            chk($sformatf("v%0d jump",    i), int'(jump),    int'(vecs[i].jmp));
            chk($sformatf("v%0d restart", i), int'(restart), int'(vecs[i].rs));
        end

        // Asynchronous reset mid-PLAY (timer is 14 here), no clock edge needed
        chk("pre-reset timer", int'(timer), 14);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_vals("async");
        @(posedge clk);
        #1;
        chk_reset_vals("held");
        @(negedge clk);
        rst = 1'b1;
        cyc = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("post frame_tick", int'(frame_tick), ((cyc % 4) == 3) ? 1 : 0);
            chk("post state", int'(state), 0);
        end
        chk("post score", int'(score), 0);
        chk("post speed", int'(speed), 6);
        chk("post timer", int'(timer), 2);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
